// File: rtl/freq_count_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module : freq_count_ctrl_if
// Brief  : Measured-signal input and two-digit display load bundle
// Rev    : 1.0  initial release
// ============================================================================
interface freq_count_ctrl_if;
  logic       signal_in;
  logic [3:0] ten_count;
  logic [3:0] unit_count;
  logic       load;
  logic       overflow;
  logic       gate;

  modport master (
    input  signal_in,
    output ten_count, unit_count, load, overflow, gate
  );

  modport slave (
    output signal_in,
    input  ten_count, unit_count, load, overflow, gate
  );
endinterface
`default_nettype wire

// File: rtl/freq_count_ctrl.sv
`default_nettype none
// ============================================================================
// Module : freq_count_ctrl
// Brief  : Gated edge counter with BCD tens/units conversion and load strobe
// Rev    : 1.0  initial release
// ============================================================================
module freq_count_ctrl #(
  parameter int UPDATE_PERIOD = 1200,
  parameter int EDGE_WIDTH    = 8
) (
  input  logic              clk,
  input  logic              reset,
  freq_count_ctrl_if.master bus
);

  typedef enum logic [1:0] {
    ST_COUNT = 2'd0,
    ST_TENS  = 2'd1,
    ST_UNITS = 2'd2,
    ST_LOAD  = 2'd3
  } state_t;

  localparam logic [15:0]           c_last_cnt = 16'(UPDATE_PERIOD - 1);
  localparam logic [EDGE_WIDTH-1:0] c_edge_max = '1;

  state_t                r_state;
  state_t                w_state_next;
  logic                  r_sync1;
  logic                  r_sync2;
  logic                  r_prev;
  logic                  w_edge;
  logic                  w_window_end;
  logic [15:0]           r_clk_cnt;
  logic [EDGE_WIDTH-1:0] r_edge_cnt;
  logic [EDGE_WIDTH-1:0] w_edge_total;
  logic [31:0]           w_edge_ext;
  logic [6:0]            w_work_init;
  logic                  w_ovf_init;
  logic [6:0]            r_work;
  logic [3:0]            r_tens_acc;
  logic [3:0]            r_units_acc;
  logic                  r_ovf_pend;
  logic [3:0]            r_ten;
  logic [3:0]            r_unit;
  logic                  r_ovf;
  logic                  r_load;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_prev  <= 1'b0;
    end else begin
      r_sync1 <= bus.signal_in;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  assign w_edge       = r_sync2 & ~r_prev;
  assign w_window_end = (r_clk_cnt == c_last_cnt);

  // Count including an edge in the final window cycle, saturating at all-ones.
  assign w_edge_total = (w_edge && (r_edge_cnt != c_edge_max)) ?
                        r_edge_cnt + EDGE_WIDTH'(1) : r_edge_cnt;
  assign w_edge_ext   = 32'(w_edge_total);
  assign w_ovf_init   = (w_edge_ext > 32'd99);
  assign w_work_init  = w_ovf_init ? 7'd99 : w_edge_ext[6:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_COUNT;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_COUNT: if (w_window_end) w_state_next = ST_TENS;
      ST_TENS:  if (r_work < 7'd10) w_state_next = ST_UNITS;
      ST_UNITS: w_state_next = ST_LOAD;
      ST_LOAD:  w_state_next = ST_COUNT;
      default:  w_state_next = ST_COUNT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_clk_cnt   <= '0;
      r_edge_cnt  <= '0;
      r_work      <= '0;
      r_tens_acc  <= '0;
      r_units_acc <= '0;
      r_ovf_pend  <= 1'b0;
      r_ten       <= '0;
      r_unit      <= '0;
      r_ovf       <= 1'b0;
      r_load      <= 1'b0;
    end else begin
      r_load <= 1'b0;
      case (r_state)
        ST_COUNT: begin
          r_clk_cnt  <= r_clk_cnt + 16'd1;
          r_edge_cnt <= w_edge_total;
          if (w_window_end) begin
            r_work     <= w_work_init;
            r_ovf_pend <= w_ovf_init;
            r_tens_acc <= '0;
          end
        end
        ST_TENS: begin
          if (r_work >= 7'd10) begin
            r_work     <= r_work - 7'd10;
            r_tens_acc <= r_tens_acc + 4'd1;
          end
        end
        ST_UNITS: begin
          r_units_acc <= r_work[3:0];
        end
        ST_LOAD: begin
          r_ten      <= r_tens_acc;
          r_unit     <= r_units_acc;
          r_ovf      <= r_ovf_pend;
          r_load     <= 1'b1;
          r_clk_cnt  <= '0;
          r_edge_cnt <= '0;
        end
        default: begin
          r_clk_cnt <= '0;
        end
      endcase
    end
  end

  // Gate follows the state directly so it drops while reset is held.
  assign bus.gate       = (r_state == ST_COUNT) && !reset;
  assign bus.ten_count  = r_ten;
  assign bus.unit_count = r_unit;
  assign bus.overflow   = r_ovf;
  assign bus.load       = r_load;

  a_bcd_legal : assert property (@(posedge clk) disable iff (reset)
    r_load |-> ((r_ten <= 4'd9) && (r_unit <= 4'd9)));

endmodule
`default_nettype wire
